// File: rtl/mult16_seq_pkg.sv
// Shared constants and state encoding for the sequential 16x16 nibble multiplier.
package mult16_seq_pkg;

   localparam int OP_W   = 16;
   localparam int NIB_W  = 4;
   localparam int PROD_W = 32;
   localparam int STEPS  = 16;
   localparam int STEP_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult16_seq_if.sv
// Operand/product handshake bundle for mult16_seq.
// master = the side offering operands and consuming products; slave = the multiplier.
interface mult16_seq_if;
   import mult16_seq_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   a;
   logic [OP_W-1:0]   b;
   logic              out_valid;
   logic              out_ready;
   logic [PROD_W-1:0] p;
   logic              busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p, busy
   );

endinterface

// File: rtl/multiplier_4_bit.sv
// Combinational 4x4 unsigned multiplier, shared across all nibble steps.
module multiplier_4_bit (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [7:0] o_p
);

   assign o_p = 8'(i_a) * 8'(i_b);

endmodule

// File: rtl/mult16_seq.sv
// Sequential 16x16 unsigned multiplier: one 4x4 nibble multiplier time-shared
// over up to 16 steps, IDLE -> CALC -> DONE handshake FSM.
// Optional build macro: MULT16_SEQ_ZERO_SKIP_EN -- skips a whole row of
// partial products when the current b nibble is zero (same product, lower latency).
module mult16_seq
   import mult16_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   mult16_seq_if.slave bus
);

   state_t              r_state;
   state_t              w_state_next;
   logic [OP_W-1:0]     r_a;
   logic [OP_W-1:0]     r_b;
   logic [PROD_W-1:0]   r_acc;
   logic [STEP_W-1:0]   r_step;

   logic [1:0]          w_i;
   logic [1:0]          w_j;
   logic [NIB_W-1:0]    w_a_nib;
   logic [NIB_W-1:0]    w_b_nib;
   logic [2*NIB_W-1:0]  w_nib_prod;
   logic [4:0]          w_shamt;
   logic [PROD_W-1:0]   w_term;
   logic                w_skip;
   logic                w_last;
   logic [STEP_W-1:0]   w_step_next;
   logic                w_in_ready;
   logic                w_out_valid;
   logic                w_busy;

   // step counter is {j,i}: i selects the a nibble, j the b nibble
   assign w_i     = r_step[1:0];
   assign w_j     = r_step[3:2];
   assign w_a_nib = r_a[{w_i, 2'b00} +: NIB_W];
   assign w_b_nib = r_b[{w_j, 2'b00} +: NIB_W];

   multiplier_4_bit u_nib_mult (
      .i_a (w_a_nib),
      .i_b (w_b_nib),
      .o_p (w_nib_prod)
   );

   // partial product weight is 16^(i+j)
   assign w_shamt = {({1'b0, w_i} + {1'b0, w_j}), 2'b00};
   assign w_term  = PROD_W'(w_nib_prod) << w_shamt;

`ifdef MULT16_SEQ_ZERO_SKIP_EN
   // at the start of a row a zero b nibble makes the whole row zero: jump to next row
   assign w_skip      = (w_i == 2'd0) && (w_b_nib == '0);
   assign w_step_next = w_skip ? {w_j + 2'd1, 2'b00} : r_step + 1'b1;
   assign w_last      = w_skip ? (w_j == 2'd3) : (r_step == STEP_W'(STEPS - 1));
`else
   assign w_skip      = 1'b0;
   assign w_step_next = r_step + 1'b1;
   assign w_last      = (r_step == STEP_W'(STEPS - 1));
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state and handshake outputs
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      w_busy       = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_state_next = CALC;
            end
         end
         CALC: begin
            w_busy = 1'b1;
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // operand latch, step counter and accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_step <= '0;
      end else if (r_state == IDLE && bus.in_valid) begin
         r_a    <= bus.a;
         r_b    <= bus.b;
         r_acc  <= '0;
         r_step <= '0;
      end else if (r_state == CALC) begin
         if (!w_skip) begin
            r_acc <= r_acc + w_term;
         end
         r_step <= w_step_next;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.busy      = w_busy;
   assign bus.p         = r_acc;

endmodule

// File: tb/tb_mult16_seq.sv
// Self-checking bench for mult16_seq: directed table, hold/reset sequences,
// and random operands against an arithmetic reference model.
module tb_mult16_seq;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   mult16_seq_if bus ();

   mult16_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
      int          lat_base;
      int          lat_skip;
   } vec_t;

`ifdef MULT16_SEQ_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // reference latency: 16 steps, or 16 - 3*(zero b nibbles) with row skipping
   function automatic int model_lat(input logic [15:0] bv);
      int z;
      z = 0;
      for (int k = 0; k < 4; k++) begin
         if (((bv >> (4 * k)) & 16'h000F) == 16'h0000) z++;
      end
      return SKIP ? (16 - 3 * z) : 16;
   endfunction

   // one full transaction; hold = extra DONE cycles with out_ready low
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input int hold,
                        output logic [31:0] got_p, output int lat);
      logic [31:0] held_p;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = ta;
      bus.b         = tbv;
      bus.out_ready = 1'b0;
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      lat = 0;
      got_p = '0;
      forever begin
         // scramble inputs while calculating; they must be ignored
         bus.in_valid = 1'($urandom);
         bus.a        = 16'($urandom);
         bus.b        = 16'($urandom);
         @(posedge clk);
         lat++;
         #1;
         if (bus.out_valid) break;
         chk("busy_calc", 32'(bus.busy), 32'd1);
         if (lat > 40) begin
            chk("latency_timeout", 32'(lat), 32'(model_lat(tbv)));
            break;
         end
      end
      got_p = bus.p;
      held_p = bus.p;
      chk("busy_done", 32'(bus.busy), 32'd0);
      chk("in_ready_done", 32'(bus.in_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'($urandom);
         bus.a        = 16'($urandom);
         bus.b        = 16'($urandom);
         @(posedge clk);
         #1;
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_p", bus.p, held_p);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      // release with in_valid high: the exit edge must not accept
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("exit_in_ready", 32'(bus.in_ready), 32'd1);
      chk("exit_out_valid", 32'(bus.out_valid), 32'd0);
      $display("[TB] op a=0x%04h b=0x%04h p=0x%08h latency=%0d", ta, tbv, got_p, lat);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_p"}, bus.p, 32'd0);
   endtask

   vec_t        vecs [6];
   logic [31:0] got_p;
   int          lat;
   logic [15:0] ra;
   logic [15:0] rb;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      vecs[0] = '{16'h1234, 16'h5678, 32'h06260060, 16, 16};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, 16};
      vecs[2] = '{16'hABCD, 16'h0100, 32'h00ABCD00, 16, 7};
      vecs[3] = '{16'h1234, 16'h0000, 32'h00000000, 16, 4};
      vecs[4] = '{16'h0000, 16'hFFFF, 32'h00000000, 16, 16};
      vecs[5] = '{16'h8001, 16'h0F0F, 32'h07878F0F, 16, 10};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;

      // directed table
      for (int k = 0; k < 6; k++) begin
         do_op(vecs[k].a, vecs[k].b, 0, got_p, lat);
         chk("table_p", got_p, vecs[k].p);
         chk("table_latency", 32'(lat), 32'(SKIP ? vecs[k].lat_skip : vecs[k].lat_base));
      end

      // hold DONE for 5 cycles, then a new op must use new operands
      do_op(16'h1234, 16'h5678, 5, got_p, lat);
      chk("hold_op_p", got_p, 32'h06260060);
      do_op(16'h0007, 16'h0009, 0, got_p, lat);
      chk("after_hold_p", got_p, 32'h0000003F);
      chk("after_hold_latency", 32'(lat), 32'(model_lat(16'h0009)));

      // reset on the edge that would process step 8
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 16'hFFFF;
      bus.b        = 16'hFFFF;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("mid_calc_reset");
      $display("[TB] reset mid-calc checked");
      do_op(16'h0003, 16'h0005, 0, got_p, lat);
      chk("post_reset_p", got_p, 32'h0000000F);
      chk("post_reset_latency", 32'(lat), 32'(model_lat(16'h0005)));

      // reset while holding a product in DONE
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 16'h00FF;
      bus.b        = 16'h00FF;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("done_before_reset", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("done_reset");
      $display("[TB] reset in DONE checked");

      // random operands, some b nibbles forced to zero
      for (int k = 0; k < 24; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         for (int n = 0; n < 4; n++) begin
            if ($urandom_range(0, 3) == 0) rb[4*n +: 4] = 4'h0;
         end
         do_op(ra, rb, int'($urandom_range(0, 2)), got_p, lat);
         chk("rand_p", got_p, 32'(ra) * 32'(rb));
         chk("rand_latency", 32'(lat), 32'(model_lat(rb)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // global watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mult16_seq.md
MULT16_SEQ -- requirements
Module: mult16_seq

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  operand pair offered.
REQ-004 SHALL have ports: in_ready  output  1  block can accept operands.
REQ-005 SHALL have ports: a  input  16  unsigned multiplicand.
REQ-006 SHALL have ports: b  input  16  unsigned multiplier.
REQ-007 SHALL have ports: out_valid  output  1  product available.
REQ-008 SHALL have ports: out_ready  input  1  consumer takes product.
REQ-009 SHALL have ports: p  output  32  unsigned product a*b.
REQ-010 SHALL have ports: busy  output  1  high in CALC state.

Function
REQ-011 SHALL compute a 16x16 unsigned product by time-sharing one 4x4 nibble multiplier over 16 steps.
REQ-012 SHALL implement states IDLE, CALC and DONE, registered.
REQ-013 SHALL drive in_ready=1 only in IDLE, busy=1 only in CALC, and out_valid=1 only in DONE.
REQ-014 SHALL accept on an edge where in_valid&in_ready, latching a and b, clearing the accumulator and step counter, and entering CALC.
REQ-015 SHALL use a 4-bit step counter {j,i}, where i is the a-nibble index (LSBs) and j is the b-nibble index (MSBs).
REQ-016 SHALL, on each CALC edge, add a_nib[i]*b_nib[j] (8-bit) shifted left by 4*(i+j) into a 32-bit accumulator, with no overflow possible.
REQ-017 SHALL enter DONE on the edge that processes step 15; out_valid then rises exactly 16 cycles after the accept edge (base build).
REQ-018 SHALL drive p from the accumulator; p is meaningful only while out_valid=1.
REQ-019 SHALL hold p and out_valid stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-020 SHALL not accept new operands in the DONE-exit cycle, because in_ready=0 in DONE; minimum accept-to-accept spacing is 18 cycles in the base build.
REQ-021 SHALL ignore in_valid, a and b while in CALC or DONE; latched operands SHALL NOT change.

Reset
REQ-022 SHALL, when rst=1 at an edge, force IDLE, clear accumulator and step counter, and drive in_ready=1, out_valid=0, busy=0, p=0.
REQ-023 SHALL, on reset asserted mid-CALC or in DONE, abandon the operation with no output; the next accept starts clean.
REQ-024 SHALL give rst priority over all handshakes on the same edge.

Configuration
REQ-025 SHALL support macro MULT16_SEQ_ZERO_SKIP_EN.
REQ-026 SHALL, when MULT16_SEQ_ZERO_SKIP_EN is defined: a CALC edge at i=0 with b_nib[j]==0 adds nothing and advances j by one (skipping that row), so each zero b-nibble costs 1 cycle instead of 4; latency = 16 - 3*(number of zero b-nibbles).
REQ-027 SHALL, when MULT16_SEQ_ZERO_SKIP_EN is undefined, always take 16 steps; the zero-check logic SHALL be absent.
REQ-028 SHALL produce a bit-identical p in both builds.

Structure
REQ-029 SHALL place in package mult16_seq_pkg: state encoding (IDLE/CALC/DONE), OP_W=16, NIB_W=4, PROD_W=32, STEPS=16.
REQ-030 SHALL instantiate the existing multiplier_4_bit once as the shared nibble multiplier; no other sub-modules.

Verification
REQ-031 SHALL cover: a=0x1234, b=0x5678, out_ready=1 -> p=0x06260060, out_valid 16 cycles after accept (both builds).
REQ-032 SHALL cover: a=0xFFFF, b=0xFFFF -> p=0xFFFE0001, latency 16.
REQ-033 SHALL cover: a=0xABCD, b=0x0100 -> p=0x00ABCD00; latency 7 with ZERO_SKIP_EN, 16 without.
REQ-034 SHALL cover: a=0x1234, b=0x0000 -> p=0; latency 4 with ZERO_SKIP_EN, 16 without.
REQ-035 SHALL cover: hold out_ready=0 for 5 cycles in DONE, toggle in_valid/a/b -> p, out_valid stable, in_ready=0; the op after release uses new operands.
REQ-036 SHALL cover: rst=1 at step 8 of CALC -> next cycle in_ready=1, out_valid=0, p=0; next op (3x5) -> p=0x0000000F.
